// File: rtl/imm_decode_stage_if.sv
// Handshake bundle for imm_decode_stage.
//   in_*  : upstream instruction channel (valid/ready, raw word, PC)
//   out_* : downstream decoded channel (valid/ready, imm, fmt, PC, PC+imm)
// The stage itself connects to the slave modport; the producer/consumer side
// (upstream fetch plus downstream consumer) connects to the master modport.
interface imm_decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_target;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_pc, out_target
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_pc, out_target
  );
endinterface

// File: rtl/imm_decode_stage.sv
// Immediate decode stage: decodes the RV immediate and instruction format of
// each incoming word, adds the immediate to the PC, and buffers the result in
// a 2-entry in-order FIFO.
//   clk, rst    : clock, asynchronous active-high reset
//   flush       : synchronous clear of all buffered entries
//   io          : imm_decode_stage_if slave (in_* upstream, out_* downstream)
//   illegal_cnt : saturating count of accepted illegal instructions
// Formats: 0=R 1=I 2=S 3=B 4=U 5=J 7=illegal.

// Combinational decoder: raw word -> format code and sign-extended immediate.
module imm_decode_unit #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [2:0]      fmt,
  output logic [XLEN-1:0] imm
);
  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  // Every format is first assembled as a 32-bit word with bit 31 = instr[31];
  // a single signed widening then covers the XLEN=64 sign extension.
  logic [31:0] raw;

  always_comb begin
    fmt = FMT_ILL;
    raw = '0;
    if (instr[1:0] == 2'b11) begin
      case (instr[6:0])
        7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
          fmt = FMT_I;
          raw = {{20{instr[31]}}, instr[31:20]};
        end
        7'b0011011: begin
          if (XLEN == 64) begin
            fmt = FMT_I;
            raw = {{20{instr[31]}}, instr[31:20]};
          end
        end
        7'b0100011: begin
          fmt = FMT_S;
          raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        end
        7'b1100011: begin
          fmt = FMT_B;
          raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                 instr[11:8], 1'b0};
        end
        7'b0110111, 7'b0010111: begin
          fmt = FMT_U;
          raw = {instr[31:12], 12'b0};
        end
        7'b1101111: begin
          fmt = FMT_J;
          raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                 instr[30:21], 1'b0};
        end
        7'b0110011: fmt = FMT_R;
        7'b0111011: begin
          if (XLEN == 64) fmt = FMT_R;
        end
        default: ;
      endcase
    end
  end

  assign imm = XLEN'($signed(raw));
endmodule

module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  imm_decode_stage_if.slave io,
  output logic [CNT_W-1:0] illegal_cnt
);
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
  } entry_t;

  logic [2:0]      dec_fmt;
  logic [XLEN-1:0] dec_imm;
  entry_t          new_e;
  entry_t          head_e;
  entry_t          mem [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      count;
  logic            rdy;
  logic            vld;
  logic            push;
  logic            pop;

  imm_decode_unit #(.XLEN(XLEN)) u_dec (
    .instr (io.in_instr),
    .fmt   (dec_fmt),
    .imm   (dec_imm)
  );

  // Decode and add happen ahead of the FIFO so each slot holds a finished
  // result; the head is then a plain register read.
  always_comb begin
    new_e        = '0;
    new_e.imm    = dec_imm;
    new_e.fmt    = dec_fmt;
    new_e.pc     = io.in_pc;
    new_e.target = io.in_pc + dec_imm;
  end

  // Ready looks at occupancy only, so a full FIFO refuses a push even when
  // the head is leaving in the same cycle.
  assign rdy  = (count != 2'd2);
  assign vld  = (count != 2'd0);
  assign push = io.in_valid & rdy & ~flush;
  assign pop  = vld & io.out_ready;

  assign head_e = mem[rd_ptr];

  assign io.in_ready   = rdy;
  assign io.out_valid  = vld;
  // Data outputs are forced to zero whenever no entry is held (stale slot
  // contents never leak out, including right after reset or flush).
  assign io.out_imm    = vld ? head_e.imm    : '0;
  assign io.out_fmt    = vld ? head_e.fmt    : '0;
  assign io.out_pc     = vld ? head_e.pc     : '0;
  assign io.out_target = vld ? head_e.target : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Slot storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_e;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_cnt <= '0;
    end else if (push && dec_fmt == FMT_ILL && illegal_cnt != '1) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_imm_decode_stage.sv
module tb_imm_decode_stage;
  typedef struct packed {
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic [63:0] pc;
    logic [63:0] tgt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_instr = '0;
  logic [63:0] s_pc = '0;
  logic        s_ordy = 1'b0;
  logic [15:0] ill32;
  logic [1:0]  ill64;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  imm_decode_stage_if #(.XLEN(32)) if32 ();
  imm_decode_stage_if #(.XLEN(64)) if64 ();

  assign if32.in_valid  = s_valid;
  assign if32.in_instr  = s_instr;
  assign if32.in_pc     = s_pc[31:0];
  assign if32.out_ready = s_ordy;
  assign if64.in_valid  = s_valid;
  assign if64.in_instr  = s_instr;
  assign if64.in_pc     = s_pc;
  assign if64.out_ready = s_ordy;

  imm_decode_stage #(.XLEN(32), .CNT_W(16)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .io(if32.slave), .illegal_cnt(ill32)
  );
  imm_decode_stage #(.XLEN(64), .CNT_W(2)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .io(if64.slave), .illegal_cnt(ill64)
  );

  task automatic chk(input string nm, input int d, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[dut%0d]: got %h expected %h at %0t", nm, d, act, exp, $time);
    end
  endtask

  // Reference model: immediates built arithmetically from the signed word.
  function automatic exp_t ref_model(input logic [31:0] ins, input logic [63:0] pc,
                                     input bit x64);
    exp_t        e;
    longint      sw;
    longint      t;
    logic [63:0] m;
    sw = longint'($signed(ins));
    m  = x64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    e.fmt = 3'd7;
    e.imm = '0;
    case (ins[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: begin e.fmt = 3'd1; t = sw >>> 20; e.imm = 64'(t); end
      7'h1B: if (x64) begin e.fmt = 3'd1; t = sw >>> 20; e.imm = 64'(t); end
      7'h23: begin
        e.fmt = 3'd2; t = sw >>> 25;
        e.imm = (64'(t) << 5) | 64'(ins[11:7]);
      end
      7'h63: begin
        e.fmt = 3'd3; t = sw >>> 31;
        e.imm = (64'(t) << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5)
              | (64'(ins[11:8]) << 1);
      end
      7'h37, 7'h17: begin e.fmt = 3'd4; e.imm = 64'(sw) & ~64'hFFF; end
      7'h6F: begin
        e.fmt = 3'd5; t = sw >>> 31;
        e.imm = (64'(t) << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11)
              | (64'(ins[30:21]) << 1);
      end
      7'h33: e.fmt = 3'd0;
      7'h3B: if (x64) e.fmt = 3'd0;
      default: ;
    endcase
    e.imm = e.imm & m;
    e.pc  = pc & m;
    e.tgt = (e.pc + e.imm) & m;
    return e;
  endfunction

  // Scoreboard / monitor
  exp_t        sb [2][$];
  exp_t        e_m;
  logic        o_v [2];
  logic        o_r [2];
  logic [2:0]  o_fmt [2];
  logic [63:0] o_imm [2];
  logic [63:0] o_pc [2];
  logic [63:0] o_tgt [2];
  logic [63:0] o_cnt [2];
  logic [63:0] mcnt [2];
  logic [63:0] mx [2];
  logic        m_rdy;

  initial begin
    mx[0] = 64'd65535;
    mx[1] = 64'd3;
    mcnt[0] = '0;
    mcnt[1] = '0;
  end

  always @(negedge clk) begin
    o_v[0] = if32.out_valid;  o_r[0] = if32.in_ready;  o_fmt[0] = if32.out_fmt;
    o_imm[0] = 64'(if32.out_imm); o_pc[0] = 64'(if32.out_pc);
    o_tgt[0] = 64'(if32.out_target); o_cnt[0] = 64'(ill32);
    o_v[1] = if64.out_valid;  o_r[1] = if64.in_ready;  o_fmt[1] = if64.out_fmt;
    o_imm[1] = if64.out_imm; o_pc[1] = if64.out_pc;
    o_tgt[1] = if64.out_target; o_cnt[1] = 64'(ill64);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        sb[d].delete();
        mcnt[d] = '0;
        chk("rst_valid", d, 64'(o_v[d]), 64'd0);
        chk("rst_ready", d, 64'(o_r[d]), 64'd1);
        chk("rst_data", d, o_imm[d] | o_pc[d] | o_tgt[d] | 64'(o_fmt[d]), 64'd0);
        chk("rst_cnt", d, o_cnt[d], 64'd0);
      end else begin
        m_rdy = (sb[d].size() < 2);
        chk("in_ready", d, 64'(o_r[d]), 64'(m_rdy));
        chk("out_valid", d, 64'(o_v[d]), 64'(sb[d].size() != 0));
        if (sb[d].size() != 0) begin
          e_m = sb[d][0];
          chk("out_fmt", d, 64'(o_fmt[d]), 64'(e_m.fmt));
          chk("out_imm", d, o_imm[d], e_m.imm);
          chk("out_pc", d, o_pc[d], e_m.pc);
          chk("out_target", d, o_tgt[d], e_m.tgt);
        end else begin
          chk("empty_data", d, o_imm[d] | o_pc[d] | o_tgt[d] | 64'(o_fmt[d]), 64'd0);
        end
        chk("illegal_cnt", d, o_cnt[d], mcnt[d]);
        if (s_ordy && sb[d].size() != 0) void'(sb[d].pop_front());
        if (flush) begin
          sb[d].delete();
        end else if (s_valid && m_rdy) begin
          e_m = ref_model(s_instr, s_pc, d == 1);
          sb[d].push_back(e_m);
          if (e_m.fmt == 3'd7 && mcnt[d] < mx[d]) mcnt[d] = mcnt[d] + 64'd1;
        end
      end
    end
  end

  // Driver
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] ins, input logic [63:0] pc);
    s_valid = 1'b1;
    s_instr = ins;
    s_pc    = pc;
    step();
  endtask

  // Push one word into an empty FIFO, check the head against spec constants,
  // then pop it.
  task automatic single(input logic [31:0] ins, input logic [63:0] pc,
                        input logic [2:0] f32, input logic [31:0] i32,
                        input logic [31:0] t32, input logic [2:0] f64,
                        input logic [63:0] i64);
    s_ordy = 1'b0;
    push(ins, pc);
    s_valid = 1'b0;
    chk("d_valid", 0, 64'(if32.out_valid), 64'd1);
    chk("d_fmt", 0, 64'(if32.out_fmt), 64'(f32));
    chk("d_imm", 0, 64'(if32.out_imm), 64'(i32));
    chk("d_target", 0, 64'(if32.out_target), 64'(t32));
    chk("d_fmt", 1, 64'(if64.out_fmt), 64'(f64));
    chk("d_imm", 1, if64.out_imm, i64);
    s_ordy = 1'b1;
    step();
    s_ordy = 1'b0;
  endtask

  logic [6:0]  ops [12];
  logic [31:0] r;
  logic [63:0] c32;
  logic [63:0] c64;

  initial begin
    ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17,
            7'h6F, 7'h33, 7'h3B};
    repeat (3) step();
    rst = 1'b0;
    step();

    // Illegal counting and saturation (CNT_W=2 on dut64)
    s_ordy = 1'b1;
    push(32'h0000_0000, 64'h100);
    push(32'h0000_007F, 64'h104);
    chk("ill_cnt2", 0, 64'(ill32), 64'd2);
    chk("ill_cnt2", 1, 64'(ill64), 64'd2);
    push(32'h0000_0000, 64'h108);
    push(32'h0000_007F, 64'h10C);
    push(32'h0000_0000, 64'h110);
    chk("ill_cnt5", 0, 64'(ill32), 64'd5);
    chk("ill_sat", 1, 64'(ill64), 64'd3);
    s_valid = 1'b0;
    step();
    s_ordy = 1'b0;

    // Directed decodes
    single(32'h0050_0093, 64'h100, 3'd1, 32'h5,        32'h105, 3'd1, 64'h5);
    single(32'hFFF0_0093, 64'h100, 3'd1, 32'hFFFF_FFFF, 32'hFF,  3'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    single(32'h0231_2023, 64'h100, 3'd2, 32'h20,       32'h120, 3'd2, 64'h20);
    single(32'hFE00_0EE3, 64'h100, 3'd3, 32'hFFFF_FFFC, 32'hFC,  3'd3, 64'hFFFF_FFFF_FFFF_FFFC);
    single(32'h0000_10B7, 64'h100, 3'd4, 32'h1000,     32'h1100, 3'd4, 64'h1000);
    single(32'h0010_006F, 64'h100, 3'd5, 32'h800,      32'h900, 3'd5, 64'h800);
    single(32'h8000_00B7, 64'h100, 3'd4, 32'h8000_0000, 32'h8000_0100, 3'd4,
           64'hFFFF_FFFF_8000_0000);
    single(32'h0000_009B, 64'h100, 3'd7, 32'h0,        32'h100, 3'd1, 64'h0);

    // Backpressure: third word held upstream, then in-order drain
    s_ordy = 1'b0;
    push(32'h0010_0093, 64'h200);
    push(32'h0020_0093, 64'h204);
    s_instr = 32'h0030_0093;
    s_pc    = 64'h208;
    chk("bp_full_ready", 0, 64'(if32.in_ready), 64'd0);
    chk("bp_full_ready", 1, 64'(if64.in_ready), 64'd0);
    step();
    step();
    chk("bp_hold_ready", 0, 64'(if32.in_ready), 64'd0);
    chk("bp_head_pc", 0, 64'(if32.out_pc), 64'h200);
    s_ordy = 1'b1;
    step();
    chk("bp_drain1_pc", 0, 64'(if32.out_pc), 64'h204);
    chk("bp_drain1_ready", 0, 64'(if32.in_ready), 64'd1);
    step();
    s_valid = 1'b0;
    chk("bp_drain2_pc", 1, if64.out_pc, 64'h208);
    step();
    chk("bp_empty", 0, 64'(if32.out_valid), 64'd0);
    s_ordy = 1'b0;

    // Flush with two buffered entries and a discarded same-cycle illegal push
    push(32'h0040_0093, 64'h300);
    push(32'h0000_0000, 64'h304);
    c32 = 64'(ill32);
    c64 = 64'(ill64);
    s_instr = 32'h0000_0000;
    flush = 1'b1;
    step();
    flush = 1'b0;
    s_valid = 1'b0;
    chk("flush_valid", 0, 64'(if32.out_valid), 64'd0);
    chk("flush_valid", 1, 64'(if64.out_valid), 64'd0);
    chk("flush_cnt", 0, 64'(ill32), c32);
    chk("flush_cnt", 1, 64'(ill64), c64);

    // Asynchronous reset with entries buffered, observed before any edge
    push(32'h0050_0093, 64'h400);
    push(32'h0060_0093, 64'h404);
    s_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 0, 64'(if32.out_valid), 64'd0);
    chk("arst_valid", 1, 64'(if64.out_valid), 64'd0);
    chk("arst_ready", 0, 64'(if32.in_ready), 64'd1);
    chk("arst_pc", 1, if64.out_pc, 64'd0);
    chk("arst_cnt", 0, 64'(ill32), 64'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s_valid = ($urandom_range(0, 9) < 7);
      r = $urandom();
      if ($urandom_range(0, 9) < 8) r[6:0] = ops[$urandom_range(0, 11)];
      s_instr = r;
      s_pc    = {$urandom(), $urandom()};
      s_ordy  = ($urandom_range(0, 9) < 6);
      flush   = ($urandom_range(0, 99) < 3);
      step();
    end
    s_valid = 1'b0;
    flush   = 1'b0;
    s_ordy  = 1'b1;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 Parameter CNT_W, default 16, width of the illegal-instruction counter.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  synchronous clear of buffered entries.
REQ-006 in_valid  input  1  upstream instruction valid.
REQ-007 in_ready  output  1  stage can accept; equals (entry count < 2).
REQ-008 in_instr  input  32  raw RV instruction word.
REQ-009 in_pc  input  XLEN  PC of in_instr.
REQ-010 out_valid  output  1  head entry valid.
REQ-011 out_ready  input  1  downstream accepts head entry.
REQ-012 out_imm  output  XLEN  sign-extended immediate of the head entry.
REQ-013 out_fmt  output  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal.
REQ-014 out_pc  output  XLEN  PC of the head entry.
REQ-015 out_target  output  XLEN  out_pc + out_imm, modulo 2^XLEN.
REQ-016 illegal_cnt  output  CNT_W  count of accepted illegal instructions.

Function
REQ-017 The block SHALL implement a 2-entry in-order FIFO; push = in_valid & in_ready & !flush; pop = out_valid & out_ready.
REQ-018 Decode and adder SHALL be evaluated before the push, so each entry stores {imm, fmt, pc, target}; latency from push to out_valid is exactly 1 cycle.
REQ-019 Opcode map: I = 0010011, 0000011, 1100111, 1110011, plus 0011011 (XLEN=64 only); S = 0100011; B = 1100011; U = 0110111, 0010111; J = 1101111; R = 0110011, plus 0111011 (XLEN=64 only).
REQ-020 Any other opcode, or instr[1:0] != 2'b11, SHALL yield fmt=7 and imm=0.
REQ-021 Immediate bit fields:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
REQ-022 All formats, U included, SHALL sign-extend from instr[31] to XLEN; R-format imm SHALL be 0.
REQ-023 out_target SHALL be computed for every format and wrap silently on overflow.
REQ-024 When the FIFO is empty, the outputs SHALL be: out_valid=0, out_imm=0, out_fmt=0, out_pc=0, out_target=0.
REQ-025 Simultaneous push and pop with 1 entry SHALL keep count=1 and advance order correctly.
REQ-026 Push is impossible when full (in_ready=0), even if a pop occurs in the same cycle; in_ready SHALL NOT depend combinationally on out_ready.
REQ-027 flush SHALL:
  - empty the FIFO on the next edge, discarding any same-cycle push;
  - still allow the same-cycle pop handshake to be observed;
  - leave illegal_cnt unchanged.
REQ-028 illegal_cnt SHALL increment on each push with fmt=7 and saturate at all-ones.
REQ-029 Entries SHALL leave only in push order; there is no reordering.

Reset
REQ-030 While rst=1, and immediately after it deasserts:
  - count=0;
  - out_valid=0, in_ready=1;
  - all data outputs 0;
  - illegal_cnt=0.
REQ-031 rst asserted mid-transfer SHALL drop all buffered entries asynchronously, with no partial output.

Verification
REQ-032 XLEN=32, pc=0x100, push 0x00500093 -> next cycle: out_fmt=1, out_imm=0x00000005, out_target=0x105.
REQ-033 Push 0xFFF00093, then 0x02312023, then 0xFE000EE3 (pc=0x100), then 0x000010B7, then 0x0010006F:
  - 0xFFF00093 -> imm=0xFFFFFFFF;
  - 0x02312023 -> fmt=2, imm=0x20;
  - 0xFE000EE3 -> fmt=3, imm=0xFFFFFFFC, target=0xFC;
  - 0x000010B7 -> fmt=4, imm=0x1000;
  - 0x0010006F -> fmt=5, imm=0x800.
REQ-034 Hold out_ready=0 and push 3 words back-to-back -> in_ready=0 after the 2nd push and the 3rd word is held upstream; then raise out_ready -> the words drain in order, one per cycle.
REQ-035 Push 0x00000000 and 0x0000007F -> fmt=7, imm=0, illegal_cnt=2; with CNT_W=2, 5 illegal pushes -> illegal_cnt=3.
REQ-036 With 2 entries buffered, assert flush for 1 cycle -> out_valid=0 next cycle and illegal_cnt unchanged; assert rst asynchronously with entries buffered -> out_valid=0 with no clock edge.
REQ-037 XLEN=64 -> 0xFFF00093 gives imm=0xFFFFFFFFFFFFFFFF, 0x800000B7 gives imm=0xFFFFFFFF80000000, 0x0000009B gives fmt=1.
